// File: rtl/clb_pkg.sv
// Shared definitions for the CLB cluster: default geometry, BLE config width, FSM states.
// Latency: none (types, constants and a constant function only).
// Backpressure: none.
package clb_pkg;

   localparam int K_DEF = 4;
   localparam int N_DEF = 2;

   // Configuration state of the cluster
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } cfg_state_t;

   // Bits per BLE: out_sel, ce_use, then a 2^K-entry truth table
   function automatic int ble_cfg_w(input int k);
      return (1 << k) + 2;
   endfunction

endpackage

// File: rtl/clb_ble.sv
// Basic logic element: K-input LUT, clock-enabled FF, output select and config gate.
// Latency: LUT path combinational; registered path one cycle.
// Backpressure: none; FF update qualified by configuration state and user clock enable.
module clb_ble
   import clb_pkg::*;
#(
   parameter int K = K_DEF,
   parameter int W = ble_cfg_w(K)
)(
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_cfg,
   input  logic [K-1:0] i_sel,
   input  logic         i_load,
   input  logic         i_done,
   input  logic         i_ce,
   output logic         o_out
);

   logic [(1<<K)-1:0] w_table;
   logic              w_lut;
   logic              w_out_sel;
   logic              w_ce_use;
   logic              w_ff_en;
   logic              r_ff;

   assign w_out_sel = i_cfg[0];
   assign w_ce_use  = i_cfg[1];
   assign w_table   = i_cfg[2 +: (1<<K)];
   assign w_lut     = w_table[i_sel];
   // FF only captures once configured; ce_use decides whether the user enable matters
   assign w_ff_en   = i_done & (~w_ce_use | i_ce);

   // Output register: cleared while a load is in progress so stale state never leaks
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ff <= 1'b0;
      end else if (i_load) begin
         r_ff <= 1'b0;
      end else if (w_ff_en) begin
         r_ff <= w_lut;
      end
   end

   // Output is held low until the whole cluster is configured
   assign o_out = i_done & (w_out_sel ? r_ff : w_lut);

endmodule

// File: rtl/clb_cluster.sv
// Cluster of N BLEs sharing one serial configuration chain with readback on chain bit 0.
// Latency: config bit shifts in on the accepting edge; done asserts on the edge of the last bit.
// Backpressure: none; prog_valid is sampled only while loading and ignored otherwise.
module clb_cluster
   import clb_pkg::*;
#(
   parameter int K = K_DEF,
   parameter int N = N_DEF
)(
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_prog_start,
   input  logic           i_prog_valid,
   input  logic           i_prog_in,
   output logic           o_prog_out,
   output logic           o_cfg_busy,
   output logic           o_cfg_done,
   input  logic           i_clb_ce,
   input  logic [N*K-1:0] i_clb_in,
   output logic [N-1:0]   o_clb_out
);

   localparam int W        = ble_cfg_w(K);
   localparam int CFG_BITS = N * W;
   localparam int CW       = $clog2(CFG_BITS + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(CFG_BITS);

   cfg_state_t          r_state;
   cfg_state_t          w_state_nxt;
   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       w_cnt_nxt;
   logic [CFG_BITS-1:0] r_chain;
   logic                w_shift;
   logic                w_load;
   logic                w_done;

   // FSM state and bit counter register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state: start restarts the load from any state and may carry bit 1 itself
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shift     = 1'b0;
      if (i_prog_start) begin
         w_state_nxt = ST_LOAD;
         w_shift     = i_prog_valid;
         w_cnt_nxt   = i_prog_valid ? CW'(1) : '0;
      end else if ((r_state == ST_LOAD) && i_prog_valid) begin
         w_shift   = 1'b1;
         w_cnt_nxt = r_cnt + CW'(1);
      end
      if (w_shift && (w_cnt_nxt == LAST_CNT)) begin
         w_state_nxt = ST_DONE;
      end
   end

   // Configuration chain: shifts toward bit 0, so the first bit loaded lands at bit 0
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_chain <= '0;
      end else if (w_shift) begin
         r_chain <= {i_prog_in, r_chain[CFG_BITS-1:1]};
      end
   end

   assign w_load     = (r_state == ST_LOAD);
   assign w_done     = (r_state == ST_DONE);
   assign o_cfg_busy = w_load;
   assign o_cfg_done = w_done;
   assign o_prog_out = r_chain[0];

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_ble
         clb_ble #(
            .K (K),
            .W (W)
         ) u_ble (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_cfg   (r_chain[g*W +: W]),
            .i_sel   (i_clb_in[g*K +: K]),
            .i_load  (w_load),
            .i_done  (w_done),
            .i_ce    (i_clb_ce),
            .o_out   (o_clb_out[g])
         );
      end
   endgenerate

endmodule

// File: tb/tb_clb_cluster.sv
module tb_clb_cluster;

   localparam int K  = 4;
   localparam int N  = 2;
   localparam int W  = (1 << K) + 2;
   localparam int CB = N * W;

   logic         clk;
   logic         rst_n;
   logic         b_start, b_valid, b_bit, b_ce;
   logic [7:0]   b_sel;
   logic         prog_out, cfg_busy, cfg_done;
   logic [1:0]   clb_out;

   int total = 0;
   int bad   = 0;

   clb_cluster #(.K(K), .N(N)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_prog_start (b_start),
      .i_prog_valid (b_valid),
      .i_prog_in    (b_bit),
      .o_prog_out   (prog_out),
      .o_cfg_busy   (cfg_busy),
      .o_cfg_done   (cfg_done),
      .i_clb_ce     (b_ce),
      .i_clb_in     (b_sel),
      .o_clb_out    (clb_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model (spec rules, queue-based chain) -------------
   bit mq[$];          // mq[j] is chain bit j; new bits enter at the back
   bit m_load, m_done;
   int m_cnt;
   bit m_ff[N];

   task automatic model_reset();
      mq.delete();
      for (int j = 0; j < CB; j++) mq.push_back(1'b0);
      m_load = 0; m_done = 0; m_cnt = 0;
      for (int i = 0; i < N; i++) m_ff[i] = 0;
   endtask

   function automatic bit m_lut(int i);
      int s;
      s = int'(b_sel[i*K +: K]);
      return mq[i*W + 2 + s];
   endfunction

   function automatic logic [7:0] m_expect();
      logic [7:0] e;
      e = '0;
      for (int i = 0; i < N; i++)
         e[i] = m_done ? (mq[i*W] ? m_ff[i] : m_lut(i)) : 1'b0;
      e[2] = mq[0];
      e[3] = m_done;
      e[4] = m_load;
      return e;
   endfunction

   task automatic m_push(bit b);
      void'(mq.pop_front());
      mq.push_back(b);
   endtask

   task automatic model_edge();
      bit nff[N];
      for (int i = 0; i < N; i++) begin
         nff[i] = m_ff[i];
         if (m_load) nff[i] = 0;
         else if (m_done && (!mq[i*W+1] || b_ce)) nff[i] = m_lut(i);
      end
      if (b_start) begin
         m_load = 1; m_done = 0; m_cnt = 0;
         if (b_valid) begin m_push(b_bit); m_cnt = 1; end
      end else if (m_load && b_valid) begin
         m_push(b_bit); m_cnt++;
      end
      if (m_load && m_cnt == CB) begin m_load = 0; m_done = 1; end
      for (int i = 0; i < N; i++) m_ff[i] = nff[i];
   endtask

   // ---------------- checking helpers --------------------------------------------
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string name);
      chk(name, {3'b000, cfg_busy, cfg_done, prog_out, clb_out}, m_expect());
   endtask

   task automatic setin(input bit st, input bit v, input bit b, input bit ce, input logic [7:0] s);
      b_start = st; b_valid = v; b_bit = b; b_ce = ce; b_sel = s;
      #2;
   endtask

   task automatic edge_();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input bit st, input bit v, input bit b, input bit ce, input logic [7:0] s);
      setin(st, v, b, ce, s);
      chk_model("model");
      edge_();
   endtask

   // Load 36 bits; start and bit 1 share a cycle, optional idle gaps between bits
   task automatic load(input logic [CB-1:0] cfg, input bit gaps);
      for (int j = 0; j < CB; j++) begin
         if (gaps && j > 0 && $urandom_range(0, 2) == 0)
            cyc(0, 0, 1'b1, b_ce, b_sel);
         cyc(j == 0, 1, cfg[j], b_ce, b_sel);
         if (j == CB-2) chk("done_before_last", {6'd0, cfg_busy, cfg_done}, 8'h02);
         if (j == CB-1) chk("done_at_last", {6'd0, cfg_busy, cfg_done}, 8'h01);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic [15:0] tbl, input bit ce_use, input bit osel);
      return {tbl, ce_use, osel};
   endfunction

   typedef struct {
      logic [7:0] sel;
      logic [1:0] exp;
   } vec_t;
   vec_t tbl[7];

   task automatic run_table(input string name);
      for (int t = 0; t < 7; t++) begin
         setin(0, 0, 0, b_ce, tbl[t].sel);
         chk(name, {6'd0, clb_out}, {6'd0, tbl[t].exp});
         chk_model("model");
         edge_();
      end
   endtask

   logic [CB-1:0] cfg_a, cfg_b, cfg_c, cfg_r;
   logic [1:0]    held;

   initial begin
      // BLE0 = AND4 (8000), BLE1 = parity (6996), both combinational
      tbl[0] = '{8'h0F, 2'b01};
      tbl[1] = '{8'h0E, 2'b00};
      tbl[2] = '{8'h1F, 2'b11};
      tbl[3] = '{8'h3F, 2'b01};
      tbl[4] = '{8'h7E, 2'b10};
      tbl[5] = '{8'hFF, 2'b01};
      tbl[6] = '{8'h80, 2'b10};
      cfg_a = {mk(16'h6996, 0, 0), mk(16'h8000, 0, 0)};
      cfg_b = {mk(16'h6996, 0, 1), mk(16'h8000, 0, 0)};
      cfg_c = {mk(16'h6996, 1, 1), mk(16'h8000, 0, 0)};

      rst_n = 1'b0;
      b_start = 0; b_valid = 0; b_bit = 0; b_ce = 0; b_sel = 8'h00;
      model_reset();
      #12;
      chk("reset_state", {3'b000, cfg_busy, cfg_done, prog_out, clb_out}, 8'h00);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Reset in the middle of a load discards everything
      cyc(1, 1, 1'b1, 0, 8'hFF);
      for (int j = 1; j < 20; j++) cyc(0, 1, 1'b1, 0, 8'hFF);
      chk("midload_busy", {7'd0, cfg_busy}, 8'h01);
      rst_n = 1'b0;
      #2;
      model_reset();
      chk("reset_midload", {3'b000, cfg_busy, cfg_done, prog_out, clb_out}, 8'h00);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(0, 1, 1'b1, 0, 8'hFF);
      chk("valid_in_idle", {3'b000, cfg_busy, cfg_done, prog_out, clb_out}, 8'h00);

      // Combinational LUT path
      load(cfg_a, 1'b1);
      setin(0, 0, 0, 0, 8'h0F);
      chk("comb_and_F", {7'd0, clb_out[0]}, 8'h01);
      setin(0, 0, 0, 0, 8'h0E);
      chk("comb_and_E", {7'd0, clb_out[0]}, 8'h00);
      run_table("table_a");

      // Surplus bit after DONE is ignored
      cyc(0, 1, ~cfg_a[0], 0, 8'h0F);
      chk("extra_bit_ignored", {4'd0, cfg_busy, cfg_done, prog_out, clb_out[0]}, {4'd0, 2'b01, cfg_a[0], 1'b1});
      cyc(1, 0, 0, 0, 8'h0F);
      chk("restart_clears", {3'b000, cfg_busy, cfg_done, prog_out, clb_out} & 8'h1B, 8'h10);

      // Registered path, ce ignored
      load(cfg_b, 1'b0);
      cyc(0, 0, 0, 0, 8'h00);
      setin(0, 0, 0, 0, 8'h10);
      chk("reg_pre_edge", {7'd0, clb_out[1]}, 8'h00);
      edge_();
      chk("reg_post_edge", {7'd0, clb_out[1]}, 8'h01);
      setin(0, 0, 0, 0, 8'h30);
      chk("reg_hold_pre", {7'd0, clb_out[1]}, 8'h01);
      edge_();
      chk("reg_post_3", {7'd0, clb_out[1]}, 8'h00);

      // Registered path gated by clb_ce
      load(cfg_c, 1'b0);
      cyc(0, 0, 0, 1, 8'h10);
      chk("ce_capture", {7'd0, clb_out[1]}, 8'h01);
      cyc(0, 0, 0, 0, 8'h00);
      cyc(0, 0, 0, 0, 8'h30);
      cyc(0, 0, 0, 0, 8'h50);
      chk("ce_hold", {7'd0, clb_out[1]}, 8'h01);
      setin(0, 0, 0, 1, 8'h00);
      chk("ce_pre_edge", {7'd0, clb_out[1]}, 8'h01);
      edge_();
      chk("ce_update", {7'd0, clb_out[1]}, 8'h00);

      // Readback: recirculate the chain through prog_out
      load(cfg_a, 1'b0);
      chk("readback_bit0", {7'd0, prog_out}, {7'd0, cfg_a[0]});
      for (int j = 0; j < CB; j++) cyc(j == 0, 1, prog_out, 0, 8'h00);
      chk("recirc_done", {6'd0, cfg_busy, cfg_done}, 8'h01);
      run_table("table_recirc");

      // Randomized traffic against the model
      for (int r = 0; r < 600; r++)
         cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
             1'($urandom), 8'($urandom));

      // Random config with recirculation
      cfg_r = {4'($urandom), 32'($urandom)};
      load(cfg_r, 1'b1);
      chk("rand_readback", {7'd0, prog_out}, {7'd0, cfg_r[0]});
      for (int r = 0; r < 20; r++) cyc(0, 0, 0, 1'($urandom), 8'($urandom));
      for (int j = 0; j < CB; j++) cyc(j == 0, 1, prog_out, 1'($urandom), 8'($urandom));
      held = clb_out;
      for (int r = 0; r < 20; r++) cyc(0, 0, 0, 1'($urandom), 8'($urandom));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
